// File: rtl/misc_v_control.sv
// rtl/misc_v_control.sv - multi-cycle control FSM for a 16-bit, 3-bit-opcode datapath
//
// Purpose: sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the
// datapath selects for each step. The only state is the FSM register; every
// control output is decoded combinationally from state, opcode, alu_zero and
// mem_ready.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   instruction  IR contents, opcode = instruction[2:0]
//   alu_zero     ALU result-equals-zero flag
//   mem_ready    memory completion, only looked at while mem_req=1
//   mem_req      memory access request
//   mem_we       memory write enable (with mem_req)
//   iord         memory address select: 0=PC, 1=ALUOut
//   ir_write     load IR from memory data
//   mdr_write    load MDR from memory data
//   pc_write     PC load enable
//   pc_src       PC source: 00=ALU, 01=ALUOut, 10=jump target
//   alu_src_a    ALU A: 0=PC, 1=rs
//   alu_src_b    ALU B: 00=rt, 01=const 2, 10=immediate
//   alu_op       00=add, 01=sub, 10=function field
//   reg_write    register file write enable
//   wb_sel       write-back source: 00=ALUOut, 01=MDR, 10=PC
//   state        current FSM state (debug)
//   retire       one-cycle pulse in the last cycle of each instruction

module misc_v_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        mdr_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        retire
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [2:0] OP_R     = 3'b000;
    localparam logic [2:0] OP_I     = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_BNE   = 3'b101;
    localparam logic [2:0] OP_J     = 3'b110;
    localparam logic [2:0] OP_JAL   = 3'b111;

    logic [2:0] opcode;
    state_t     next_state;
    logic       unused_instr_bits;

    assign opcode            = instruction[2:0];
    assign unused_instr_bits = ^instruction[15:3];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are gated by reset directly so a pending memory request is
    // dropped in the very cycle reset is seen, not one cycle later.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        wb_sel     = 2'b00;
        retire     = 1'b0;
        next_state = S_FETCH;

        if (!reset) begin
            case (state)
                S_FETCH: begin
                    // PC <= PC + 2 through the ALU while the fetch completes
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        next_state = S_DECODE;
                    end else begin
                        next_state = S_FETCH;
                    end
                end
                S_DECODE: begin
                    // speculative branch target into ALUOut
                    alu_src_b  = 2'b10;
                    next_state = S_EXEC;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_R: begin
                            alu_src_a  = 1'b1;
                            alu_op     = 2'b10;
                            next_state = S_WB;
                        end
                        OP_I: begin
                            alu_src_a  = 1'b1;
                            alu_src_b  = 2'b10;
                            alu_op     = 2'b10;
                            next_state = S_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_a  = 1'b1;
                            alu_src_b  = 2'b10;
                            next_state = S_MEM;
                        end
                        OP_BEQ, OP_BNE: begin
                            alu_src_a  = 1'b1;
                            alu_op     = 2'b01;
                            pc_src     = 2'b01;
                            pc_write   = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;
                            retire     = 1'b1;
                            next_state = S_FETCH;
                        end
                        default: begin
                            // j / jal: PC already holds PC+2, so the link
                            // write sees the return address this cycle
                            pc_write   = 1'b1;
                            pc_src     = 2'b10;
                            retire     = 1'b1;
                            if (opcode == OP_JAL) begin
                                reg_write = 1'b1;
                                wb_sel    = 2'b10;
                            end
                            next_state = S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (opcode == OP_STORE);
                    if (mem_ready) begin
                        if (opcode == OP_STORE) begin
                            retire     = 1'b1;
                            next_state = S_FETCH;
                        end else begin
                            mdr_write  = 1'b1;
                            next_state = S_WB;
                        end
                    end else begin
                        next_state = S_MEM;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    wb_sel     = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
                default: begin
                    next_state = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_misc_v_control.sv
// tb/tb_misc_v_control.sv - randomized trace checker for misc_v_control

module tb_misc_v_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instruction;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_write, mdr_write, pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b, alu_op;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic        retire;

    int errors = 0;
    int checks = 0;

    misc_v_control dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .mdr_write(mdr_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
        .state(state), .retire(retire)
    );

    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, retire};

    // Expected output vector, same field order as obs
    function automatic logic [16:0] o(input int mreq, input int we, input int io,
                                      input int irw, input int mdrw, input int pcw,
                                      input int pcs, input int asa, input int asb,
                                      input int aop, input int rw, input int wbs,
                                      input int ret);
        return {mreq[0], we[0], io[0], irw[0], mdrw[0], pcw[0], pcs[1:0],
                asa[0], asb[1:0], aop[1:0], rw[0], wbs[1:0], ret[0]};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare after settling
    task automatic step(input int est, input logic [16:0] eo, input logic mr,
                        input logic [15:0] ins, input logic az, input string tag);
        @(negedge clk);
        mem_ready   = mr;
        instruction = ins;
        alu_zero    = az;
        #1;
        check({tag, " state"}, 32'(state), 32'(est));
        check({tag, " out"}, 32'(obs), 32'(eo));
    endtask

    // Builds the expected per-cycle trace of one instruction from the rules:
    // wf fetch wait cycles, wm memory wait cycles, az_exec <0 means random.
    task automatic run_instr(input int op, input int wf, input int wm, input int az_exec);
        string       t;
        logic [15:0] ins;
        logic        az;
        logic        pcw;
        t   = $sformatf("op%0d", op);
        for (int i = 0; i < wf; i++)
            step(0, o(1,0,0,0,0,0,0,0,1,0,0,0,0), 1'b0, 16'($urandom), rb(), {t, " fetch_wait"});
        step(0, o(1,0,0,1,0,1,0,0,1,0,0,0,0), 1'b1, 16'($urandom), rb(), {t, " fetch_rdy"});
        step(1, o(0,0,0,0,0,0,0,0,2,0,0,0,0), rb(), 16'($urandom), rb(), {t, " decode"});

        ins = {13'($urandom), 3'(op)};
        az  = (az_exec < 0) ? rb() : az_exec[0];
        case (op)
            0: step(2, o(0,0,0,0,0,0,0,1,0,2,0,0,0), rb(), ins, az, {t, " exec"});
            1: step(2, o(0,0,0,0,0,0,0,1,2,2,0,0,0), rb(), ins, az, {t, " exec"});
            2, 3: step(2, o(0,0,0,0,0,0,0,1,2,0,0,0,0), rb(), ins, az, {t, " exec"});
            4, 5: begin
                pcw = (op == 4) ? az : ~az;
                step(2, o(0,0,0,0,0,int'(pcw),1,1,0,1,0,0,1), rb(), ins, az, {t, " exec"});
            end
            6: step(2, o(0,0,0,0,0,1,2,0,0,0,0,0,1), rb(), ins, az, {t, " exec"});
            default: step(2, o(0,0,0,0,0,1,2,0,0,0,1,2,1), rb(), ins, az, {t, " exec"});
        endcase

        if (op == 2 || op == 3) begin
            for (int i = 0; i < wm; i++)
                step(3, o(1,(op == 3) ? 1 : 0,1,0,0,0,0,0,0,0,0,0,0), 1'b0, ins, rb(),
                     {t, " mem_wait"});
            if (op == 3)
                step(3, o(1,1,1,0,0,0,0,0,0,0,0,0,1), 1'b1, ins, rb(), {t, " mem_rdy"});
            else
                step(3, o(1,0,1,0,1,0,0,0,0,0,0,0,0), 1'b1, ins, rb(), {t, " mem_rdy"});
        end
        if (op <= 2)
            step(4, o(0,0,0,0,0,0,0,0,0,0,1,(op == 2) ? 1 : 0,1), rb(), ins, rb(), {t, " wb"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        mem_ready   = 1'b0;
        alu_zero    = 1'b0;
        instruction = 16'h0;
        repeat (2) @(posedge clk);

        // Held in reset with ready asserted: outputs silent, state FETCH
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("reset state", 32'(state), 32'd0);
        check("reset out", 32'(obs), 32'd0);

        // First cycle after reset: FETCH with mem_req=1, iord=0
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("post_reset state", 32'(state), 32'd0);
        check("post_reset out", 32'(obs), 32'(o(1,0,0,0,0,0,0,0,1,0,0,0,0)));

        // Directed cases
        run_instr(0, 0, 0, -1);   // R-type, zero wait
        run_instr(2, 0, 3, -1);   // load, 3 memory wait cycles
        run_instr(4, 0, 0, 1);    // beq taken
        run_instr(4, 0, 0, 0);    // beq not taken
        run_instr(5, 0, 0, 1);    // bne not taken
        run_instr(5, 0, 0, 0);    // bne taken
        run_instr(7, 1, 0, -1);   // jal
        run_instr(3, 0, 0, -1);   // store, zero wait
        run_instr(6, 2, 0, -1);   // j

        // Store interrupted by reset during the memory wait
        step(0, o(1,0,0,1,0,1,0,0,1,0,0,0,0), 1'b1, 16'h0003, 1'b0, "st_rst fetch");
        step(1, o(0,0,0,0,0,0,0,0,2,0,0,0,0), 1'b0, 16'h0003, 1'b0, "st_rst decode");
        step(2, o(0,0,0,0,0,0,0,1,2,0,0,0,0), 1'b0, 16'h0003, 1'b0, "st_rst exec");
        step(3, o(1,1,1,0,0,0,0,0,0,0,0,0,0), 1'b0, 16'h0003, 1'b0, "st_rst mem_wait");
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("st_rst reset state", 32'(state), 32'd3);
        check("st_rst reset out", 32'(obs), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("st_rst after state", 32'(state), 32'd0);
        check("st_rst after out", 32'(obs), 32'(o(1,0,0,0,0,0,0,0,1,0,0,0,0)));

        // Randomized instruction stream
        for (int n = 0; n < 120; n++)
            run_instr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3), -1);

        // Illegal state encoding: all outputs zero, then back to FETCH
        @(negedge clk);
        mem_ready = 1'b1;
        force dut.state = 3'd6;
        #1;
        check("illegal state", 32'(state), 32'd6);
        check("illegal out", 32'(obs), 32'd0);
        release dut.state;
        step(0, o(1,0,0,0,0,0,0,0,1,0,0,0,0), 1'b0, 16'h0000, 1'b0, "illegal recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
